ascon_decrypt_verify: RTL and testbench
=======================================

// Module: ascon_decrypt_verify
// PURPOSE
//  Sequential ASCON-128 decryption and tag-verification engine; receive-side counterpart of the combinational encrypt chain.
//  Holds the 320-bit state x0..x4 in registers and runs one permutation round per clock (two with the macro below).
//  Streams ciphertext in, plaintext out; checks the supplied 128-bit tag. Full 64-bit blocks only.
// PARAMETERS
//  PA_ROUNDS  12                     rounds of p^a (init, final)
//  PB_ROUNDS  6                      rounds of p^b (per AD/CT block)
//  IV         64'h80400c0600000000   ASCON-128 initial value
// PORTS
//  clk      in   1    clock, rising edge
//  rst_n    in   1    asynchronous active-low reset
//  start    in   1    begin operation; accepted only in IDLE
//  key      in   128  K0=key[127:64], K1=key[63:0]; sampled on accepted start
//  nonce    in   128  N0=nonce[127:64], N1=nonce[63:0]; sampled on accepted start
//  tag_in   in   128  expected tag; sampled on accepted start
//  ad_none  in   1    no associated data; sampled on accepted start
//  ct_none  in   1    no ciphertext; sampled on accepted start
//  ad_valid / ad_ready / ad_last / ad_data[63:0]    AD stream, valid/ready
//  ct_valid / ct_ready / ct_last / ct_data[63:0]    ciphertext stream, valid/ready
//  pt_valid out  1    one-cycle pulse, pt_data valid
//  pt_data  out  64   plaintext block
//  busy     out  1    high in any state other than IDLE
//  done     out  1    one-cycle pulse at end of operation
//  tag_ok   out  1    tag compare result; valid with done, held until next start
// BEHAVIOUR
//  Reset: FSM=IDLE; state, key, tag and round-counter registers, and all outputs (busy, done, tag_ok, pt_valid, pt_data, ad_ready, ct_ready) = 0.
//  FSM: IDLE -> INIT -> [AD_WAIT <-> AD_PERM]* -> AD_PAD -> [CT_WAIT <-> CT_PERM]* -> FINAL -> CHECK -> IDLE.
//  IDLE: on start, state <= {IV, K0, K1, N0, N1}; go to INIT.
//  INIT: PA_ROUNDS rounds, constants c_i = {4'hF-i, i}, i = 0..11. Last round write also does x3^=K0, x4^=K1.
//  INIT exit: to AD_WAIT, or straight to the domain-separation step if ad_none.
//  AD_WAIT: ad_ready=1. On a handshake, x0 ^= ad_data, then AD_PERM.
//  AD_PERM: PB_ROUNDS rounds (i = 6..11). Returns to AD_WAIT, or to AD_PAD if the block carried ad_last.
//  AD_PAD: x0 ^= 64'h8000_0000_0000_0000, then PB_ROUNDS rounds.
//  Domain separation: x4 ^= 1, applied on the transition into CT_WAIT (or into FINAL if ct_none).
//  CT_WAIT: ct_ready=1. On a handshake, pt_data <= x0 ^ ct_data and pt_valid pulses next cycle; x0 <= ct_data; then CT_PERM.
//  CT_PERM: PB_ROUNDS rounds. Returns to CT_WAIT, or after ct_last applies x0 ^= 64'h8000.. and enters FINAL.
//  FINAL: x1 ^= K0, x2 ^= K1, then PA_ROUNDS rounds. Last round write does x3 ^= K0, x4 ^= K1.
//  CHECK: tag_ok <= ({x3,x4} == tag_in), full 128-bit compare, no early exit; done pulses; back to IDLE.
//  ready is never asserted outside its WAIT state; valid held without ready stalls indefinitely, no state change.
//  ad_* ignored when ad_none=1; ct_* ignored when ct_none=1.
//  start while busy: ignored. Key, nonce, tag and none-flags changing while busy: no effect.
//  rst_n low mid-operation: immediate return to reset values; no partial pt_valid or done.
//  Latency with no AD/CT and R rounds/cycle: done high 2*PA_ROUNDS/R + 1 cycles after the start cycle (25 for R=1).
//  Each AD or CT block costs PB_ROUNDS/R cycles plus 1 handshake cycle.
//  Plaintext is released before tag check (RUP); the consumer must discard it when tag_ok=0.
// CONFIGURATION
//  ASCON_UNROLL2_EN defined: two round instances chained per cycle, R=2; counter steps by 2. Init 6, PB 3, final 6 cycles.
//  ASCON_UNROLL2_EN undefined: single round instance, R=1. Outputs bit-identical in both modes; only cycle counts differ.
// STRUCTURE
//  Shared package ascon_pkg: ASCON_IV, PAD_WORD (64'h8000_0000_0000_0000), round-constant function rc(i), FSM state enum, PA/PB defaults.
//  Sub-module ascon_round: combinational single round (constant add, 5-bit S-box, linear layer), 320-bit in/out plus 8-bit rc.
//  Top: FSM, round counter, state register, key/tag holding registers, stream handshakes, tag comparator.
// TESTING
//  KAT 1: key=nonce=0x000102..0F, ad_none=ct_none=1, tag_in=E355159F292911F794CB1432A0103A8A -> tag_ok=1, done at cycle 25.
//  Same as KAT 1 with tag_in bit 0 flipped -> done at cycle 25, tag_ok=0.
//  Round-trip: encrypt 3 AD + 2 PT blocks with reference encryptor, feed CT and tag -> pt_data equals the PT, tag_ok=1.
//  Random ad_valid/ct_valid gaps and start pulses while busy -> identical pt_data and tag_ok, no extra pt_valid.
//  rst_n low during CT_PERM -> all outputs 0 next cycle; a following KAT 1 run passes.
//  ASCON_UNROLL2_EN build, KAT 1 and round-trip -> same results; KAT 1 done at cycle 13.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared definitions for the ASCON-128 decrypt/verify engine.
//   ASCON_IV    : ASCON-128 initial value word
//   PAD_WORD    : padding word XORed into x0 after the last full block
//   PA_DEFAULT  : rounds of p^a (initialisation, finalisation)
//   PB_DEFAULT  : rounds of p^b (per AD / CT block)
//   state_e     : control FSM states
//   rc(i)       : round constant for round index i of the 12-round schedule
//   ror64(v,n)  : 64-bit rotate right
package ascon_pkg;

  localparam logic [63:0] ASCON_IV   = 64'h80400c0600000000;
  localparam logic [63:0] PAD_WORD   = 64'h8000_0000_0000_0000;
  localparam int unsigned PA_DEFAULT = 12;
  localparam int unsigned PB_DEFAULT = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_AD_WAIT,
    ST_AD_PERM,
    ST_AD_PAD,
    ST_CT_WAIT,
    ST_CT_PERM,
    ST_FINAL,
    ST_CHECK
  } state_e;

  // c_i = {0xF - i, i}; p^b uses the tail of the same schedule (i = 6..11)
  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON permutation round.
//   s_in  [319:0] : state {x0,x1,x2,x3,x4}, x0 in the top word
//   rcon  [7:0]   : round constant, XORed into the low byte of x2
//   s_out [319:0] : state after constant addition, S-box layer, linear layer
module ascon_round
  import ascon_pkg::*;
(
  input  logic [319:0] s_in,
  input  logic [7:0]   rcon,
  output logic [319:0] s_out
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;

  always_comb begin
    // constant addition folded into the S-box input XORs
    a0 = s_in[319:256] ^ s_in[63:0];
    a1 = s_in[255:192];
    a2 = s_in[191:128] ^ {56'd0, rcon} ^ s_in[255:192];
    a3 = s_in[127:64];
    a4 = s_in[63:0] ^ s_in[127:64];
    // chi-like core of the 5-bit S-box, bit-sliced over 64 columns
    b0 = a0 ^ (~a1 & a2);
    b1 = a1 ^ (~a2 & a3);
    b2 = a2 ^ (~a3 & a4);
    b3 = a3 ^ (~a4 & a0);
    b4 = a4 ^ (~a0 & a1);
    // S-box output XORs; x1 and x3 use x0/x2 before their own updates
    c0 = b0 ^ b4;
    c1 = b1 ^ b0;
    c2 = ~b2;
    c3 = b3 ^ b2;
    c4 = b4;
    s_out = {c0 ^ ror64(c0, 19) ^ ror64(c0, 28),
             c1 ^ ror64(c1, 61) ^ ror64(c1, 39),
             c2 ^ ror64(c2, 1)  ^ ror64(c2, 6),
             c3 ^ ror64(c3, 10) ^ ror64(c3, 17),
             c4 ^ ror64(c4, 7)  ^ ror64(c4, 41)};
  end

endmodule

// File: rtl/ascon_decrypt_verify.sv
// Sequential ASCON-128 decryption and tag verification, one round per clock
// (two per clock when ASCON_UNROLL2_EN is defined). Full 64-bit blocks only.
// Plaintext is released before the tag is checked; discard it if tag_ok=0.
//   clk, rst_n                 : clock (rising edge), async active-low reset
//   start                      : begin operation, accepted only in IDLE
//   key, nonce, tag_in         : 128-bit operands, sampled on accepted start
//   ad_none, ct_none           : empty AD / CT flags, sampled on accepted start
//   ad_valid/ready/last/data   : associated-data stream
//   ct_valid/ready/last/data   : ciphertext stream
//   pt_valid, pt_data          : plaintext block, one-cycle pulse
//   busy                       : high whenever not IDLE
//   done                       : one-cycle pulse at end of operation
//   tag_ok                     : tag compare result, valid with done
// Macro ASCON_UNROLL2_EN: chain two round instances per cycle.
module ascon_decrypt_verify
  import ascon_pkg::*;
#(
  parameter int unsigned PA_ROUNDS = PA_DEFAULT,
  parameter int unsigned PB_ROUNDS = PB_DEFAULT,
  parameter logic [63:0] IV        = ASCON_IV
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic [127:0] tag_in,
  input  logic         ad_none,
  input  logic         ct_none,
  input  logic         ad_valid,
  output logic         ad_ready,
  input  logic         ad_last,
  input  logic [63:0]  ad_data,
  input  logic         ct_valid,
  output logic         ct_ready,
  input  logic         ct_last,
  input  logic [63:0]  ct_data,
  output logic         pt_valid,
  output logic [63:0]  pt_data,
  output logic         busy,
  output logic         done,
  output logic         tag_ok
);

`ifdef ASCON_UNROLL2_EN
  localparam int unsigned R = 2;
`else
  localparam int unsigned R = 1;
`endif
  localparam logic [3:0] RSTEP    = 4'(R);
  localparam logic [3:0] PA_START = 4'(12 - PA_ROUNDS);
  localparam logic [3:0] PB_START = 4'(12 - PB_ROUNDS);
  localparam logic [3:0] RND_LAST = 4'(12 - R);

  state_e       fsm;
  logic [319:0] st;
  logic [63:0]  k0, k1;
  logic [127:0] tag_r;
  logic         ad_none_r, ct_none_r, ad_last_r, ct_last_r;
  logic [3:0]   rnd;
  logic         last_rnd;

  logic [319:0] r0_out, perm_out;
  logic [319:0] key_tail, key_mid, pad_x0, leave_ad;

  ascon_round u_round0 (.s_in(st), .rcon(rc(rnd)), .s_out(r0_out));

`ifdef ASCON_UNROLL2_EN
  ascon_round u_round1 (.s_in(r0_out), .rcon(rc(rnd + 4'd1)), .s_out(perm_out));
`else
  assign perm_out = r0_out;
`endif

  assign last_rnd = (rnd == RND_LAST);
  assign key_tail = {192'd0, k0, k1};
  assign key_mid  = {64'd0, k0, k1, 128'd0};
  assign pad_x0   = {PAD_WORD, 256'd0};

  // Every XOR that belongs between two permutations is folded into the
  // write of the preceding permutation's last round, so no cycle is spent
  // on the key / padding / domain-separation steps.
  always_comb begin
    leave_ad = perm_out ^ {256'd0, 64'd1};
    if (fsm == ST_INIT) leave_ad = leave_ad ^ key_tail;
    if (ct_none_r)      leave_ad = leave_ad ^ pad_x0 ^ key_mid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= ST_IDLE;
      st        <= '0;
      k0        <= '0;
      k1        <= '0;
      tag_r     <= '0;
      ad_none_r <= 1'b0;
      ct_none_r <= 1'b0;
      ad_last_r <= 1'b0;
      ct_last_r <= 1'b0;
      rnd       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tag_ok    <= 1'b0;
      pt_valid  <= 1'b0;
      pt_data   <= '0;
      ad_ready  <= 1'b0;
      ct_ready  <= 1'b0;
    end else begin
      done     <= 1'b0;
      pt_valid <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (start) begin
            st        <= {IV, key, nonce};
            k0        <= key[127:64];
            k1        <= key[63:0];
            tag_r     <= tag_in;
            ad_none_r <= ad_none;
            ct_none_r <= ct_none;
            rnd       <= PA_START;
            tag_ok    <= 1'b0;
            busy      <= 1'b1;
            fsm       <= ST_INIT;
          end
        end
        ST_INIT, ST_AD_PAD: begin
          rnd <= rnd + RSTEP;
          if (!last_rnd) begin
            st <= perm_out;
          end else if (fsm == ST_INIT && !ad_none_r) begin
            st       <= perm_out ^ key_tail;
            ad_ready <= 1'b1;
            fsm      <= ST_AD_WAIT;
          end else begin
            st  <= leave_ad;
            rnd <= PA_START;
            if (ct_none_r) begin
              fsm <= ST_FINAL;
            end else begin
              ct_ready <= 1'b1;
              fsm      <= ST_CT_WAIT;
            end
          end
        end
        ST_AD_WAIT: begin
          if (ad_valid) begin
            st[319:256] <= st[319:256] ^ ad_data;
            ad_last_r   <= ad_last;
            ad_ready    <= 1'b0;
            rnd         <= PB_START;
            fsm         <= ST_AD_PERM;
          end
        end
        ST_AD_PERM: begin
          rnd <= rnd + RSTEP;
          if (!last_rnd) begin
            st <= perm_out;
          end else if (ad_last_r) begin
            st  <= perm_out ^ pad_x0;
            rnd <= PB_START;
            fsm <= ST_AD_PAD;
          end else begin
            st       <= perm_out;
            ad_ready <= 1'b1;
            fsm      <= ST_AD_WAIT;
          end
        end
        ST_CT_WAIT: begin
          if (ct_valid) begin
            pt_data     <= st[319:256] ^ ct_data;
            pt_valid    <= 1'b1;
            st[319:256] <= ct_data;
            ct_last_r   <= ct_last;
            ct_ready    <= 1'b0;
            rnd         <= PB_START;
            fsm         <= ST_CT_PERM;
          end
        end
        ST_CT_PERM: begin
          rnd <= rnd + RSTEP;
          if (!last_rnd) begin
            st <= perm_out;
          end else if (ct_last_r) begin
            st  <= perm_out ^ pad_x0 ^ key_mid;
            rnd <= PA_START;
            fsm <= ST_FINAL;
          end else begin
            st       <= perm_out;
            ct_ready <= 1'b1;
            fsm      <= ST_CT_WAIT;
          end
        end
        ST_FINAL: begin
          rnd <= rnd + RSTEP;
          if (!last_rnd) begin
            st <= perm_out;
          end else begin
            st  <= perm_out ^ key_tail;
            fsm <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          tag_ok <= (st[127:0] == tag_r);
          done   <= 1'b1;
          busy   <= 1'b0;
          fsm    <= ST_IDLE;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_decrypt_verify.sv
// Directed bench for ascon_decrypt_verify: official KAT tag, a round trip
// through an independent table-driven reference encryptor, stream gaps with
// start pulses while busy, and reset in the middle of an operation.
module tb_ascon_decrypt_verify;

`ifdef ASCON_UNROLL2_EN
  localparam int LAT_KAT = 13;
  localparam int LAT_RT  = 36;
`else
  localparam int LAT_KAT = 25;
  localparam int LAT_RT  = 66;
`endif

  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KAT_TAG = 128'hE355159F292911F794CB1432A0103A8A;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0, nonce = '0, tag_in = '0;
  logic         ad_none = 1'b0, ct_none = 1'b0;
  logic         ad_valid = 1'b0, ad_last = 1'b0;
  logic [63:0]  ad_data = '0;
  logic         ct_valid = 1'b0, ct_last = 1'b0;
  logic [63:0]  ct_data = '0;
  logic         ad_ready, ct_ready, pt_valid, busy, done, tag_ok;
  logic [63:0]  pt_data;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0]  ad_blk [3];
  logic [63:0]  pt_blk [2];
  logic [63:0]  ct_blk [2];
  int           n_ad, n_ct;
  bit           use_gaps, pulse_busy, junk;
  bit           fin;
  int           done_cyc, ready_cnt;
  logic         got_tag;
  logic [63:0]  pt_got [$];

  always #5 clk = ~clk;

  ascon_decrypt_verify dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .nonce(nonce),
    .tag_in(tag_in), .ad_none(ad_none), .ct_none(ct_none),
    .ad_valid(ad_valid), .ad_ready(ad_ready), .ad_last(ad_last), .ad_data(ad_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_last(ct_last), .ct_data(ct_data),
    .pt_valid(pt_valid), .pt_data(pt_data), .busy(busy), .done(done), .tag_ok(tag_ok));

  // ---------------- reference encryptor (S-box by table lookup) ----------
  function automatic logic [63:0] rr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] m_round(input logic [319:0] s, input logic [7:0] c);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, o;
    for (int j = 0; j < 5; j++) x[j] = s[319 - 64*j -: 64];
    x[2][7:0] = x[2][7:0] ^ c;
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o = SBOX[col];
      y[0][b] = o[4]; y[1][b] = o[3]; y[2][b] = o[2]; y[3][b] = o[1]; y[4][b] = o[0];
    end
    return {y[0] ^ rr(y[0], 19) ^ rr(y[0], 28), y[1] ^ rr(y[1], 61) ^ rr(y[1], 39),
            y[2] ^ rr(y[2], 1)  ^ rr(y[2], 6),  y[3] ^ rr(y[3], 10) ^ rr(y[3], 17),
            y[4] ^ rr(y[4], 7)  ^ rr(y[4], 41)};
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s, input int nr);
    logic [319:0] t = s;
    for (int i = 12 - nr; i < 12; i++) t = m_round(t, 8'(((15 - i) << 4) | i));
    return t;
  endfunction

  task automatic m_encrypt(input logic [127:0] k, input logic [127:0] n, output logic [127:0] tg);
    logic [319:0] s;
    s = m_perm({64'h80400c0600000000, k, n}, 12) ^ {192'd0, k};
    if (n_ad > 0) begin
      for (int i = 0; i < n_ad; i++) begin
        s[319:256] = s[319:256] ^ ad_blk[i];
        s = m_perm(s, 6);
      end
      s[319:256] = s[319:256] ^ 64'h8000_0000_0000_0000;
      s = m_perm(s, 6);
    end
    s[0] = s[0] ^ 1'b1;
    for (int i = 0; i < n_ct; i++) begin
      s[319:256] = s[319:256] ^ pt_blk[i];
      ct_blk[i] = s[319:256];
      s = m_perm(s, 6);
    end
    s[319:256] = s[319:256] ^ 64'h8000_0000_0000_0000;
    s = m_perm(s ^ {64'd0, k, 128'd0}, 12);
    tg = s[127:0] ^ k;
  endtask

  // ---------------- operation driver ----------------
  task automatic drive_streams();
    @(negedge clk);
    for (int i = 0; i < n_ad; i++) begin
      if (use_gaps) repeat ($urandom_range(0, 10)) @(negedge clk);
      ad_valid = 1'b1; ad_data = ad_blk[i]; ad_last = (i == n_ad - 1);
      while (!ad_ready && !fin) @(negedge clk);
      @(negedge clk);
      ad_valid = 1'b0; ad_last = 1'b0;
    end
    for (int i = 0; i < n_ct; i++) begin
      if (use_gaps) repeat ($urandom_range(0, 10)) @(negedge clk);
      ct_valid = 1'b1; ct_data = ct_blk[i]; ct_last = (i == n_ct - 1);
      while (!ct_ready && !fin) @(negedge clk);
      @(negedge clk);
      ct_valid = 1'b0; ct_last = 1'b0;
    end
  endtask

  task automatic run_op(input logic [127:0] k, input logic [127:0] n, input logic [127:0] t);
    @(negedge clk);
    key = k; nonce = n; tag_in = t;
    ad_none = (n_ad == 0); ct_none = (n_ct == 0);
    if (junk) begin
      ad_valid = 1'b1; ad_data = '1; ad_last = 1'b1;
      ct_valid = 1'b1; ct_data = '1; ct_last = 1'b1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fin = 1'b0; done_cyc = -1; ready_cnt = 0; got_tag = 1'bx;
    pt_got.delete();
    fork
      begin
        for (int c = 1; c <= 3000 && !fin; c++) begin
          @(posedge clk); #1;
          if (ad_ready || ct_ready) ready_cnt++;
          if (pt_valid) pt_got.push_back(pt_data);
          if (done) begin done_cyc = c; got_tag = tag_ok; fin = 1'b1; end
        end
        fin = 1'b1;
      end
      drive_streams();
      begin
        while (!fin) begin
          @(negedge clk);
          if (pulse_busy) begin
            if (busy && !fin) begin
              start = 1'b1;
              key = key ^ {4{$urandom()}};
              nonce = nonce ^ {4{$urandom()}};
              tag_in = ~tag_in;
              ad_none = ~ad_none;
              ct_none = 1'($urandom());
            end else begin
              start = 1'b0;
            end
          end
        end
        start = 1'b0;
      end
    join
    ad_valid = 1'b0; ct_valid = 1'b0; ad_last = 1'b0; ct_last = 1'b0;
    junk = 1'b0; use_gaps = 1'b0; pulse_busy = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (tag_ok !== 1'b0) begin miscompares++; $display("FAIL reset_tag_ok got=%b exp=0", tag_ok); end
    vectors++; if (pt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pt_valid got=%b exp=0", pt_valid); end
    vectors++; if (pt_data !== 64'd0) begin miscompares++; $display("FAIL reset_pt_data got=%h exp=0", pt_data); end
    vectors++; if (ad_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ad_ready got=%b exp=0", ad_ready); end
    vectors++; if (ct_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ct_ready got=%b exp=0", ct_ready); end
  endtask

  task automatic test_kat1();
    n_ad = 0; n_ct = 0; junk = 1'b1;
    run_op(KAT_KEY, KAT_KEY, KAT_TAG);
    vectors++; if (done_cyc !== LAT_KAT) begin miscompares++; $display("FAIL kat1_latency got=%0d exp=%0d", done_cyc, LAT_KAT); end
    vectors++; if (got_tag !== 1'b1) begin miscompares++; $display("FAIL kat1_tag_ok got=%b exp=1", got_tag); end
    vectors++; if (ready_cnt !== 0) begin miscompares++; $display("FAIL kat1_ready_cycles got=%0d exp=0", ready_cnt); end
    vectors++; if (pt_got.size() !== 0) begin miscompares++; $display("FAIL kat1_pt_count got=%0d exp=0", pt_got.size()); end
  endtask

  task automatic test_bad_tag();
    n_ad = 0; n_ct = 0;
    run_op(KAT_KEY, KAT_KEY, KAT_TAG ^ 128'd1);
    vectors++; if (done_cyc !== LAT_KAT) begin miscompares++; $display("FAIL badtag_latency got=%0d exp=%0d", done_cyc, LAT_KAT); end
    vectors++; if (got_tag !== 1'b0) begin miscompares++; $display("FAIL badtag_tag_ok got=%b exp=0", got_tag); end
  endtask

  task automatic check_roundtrip(input string nm, input logic [127:0] k,
                                 input logic [127:0] n, input logic [127:0] t, input bit chk_lat);
    run_op(k, n, t);
    vectors++; if (pt_got.size() !== 2) begin miscompares++; $display("FAIL %s_pt_count got=%0d exp=2", nm, pt_got.size()); end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (i >= pt_got.size()) begin
        miscompares++; $display("FAIL %s_pt%0d got=none exp=%h", nm, i, pt_blk[i]);
      end else if (pt_got[i] !== pt_blk[i]) begin
        miscompares++; $display("FAIL %s_pt%0d got=%h exp=%h", nm, i, pt_got[i], pt_blk[i]);
      end
    end
    vectors++; if (got_tag !== 1'b1) begin miscompares++; $display("FAIL %s_tag_ok got=%b exp=1", nm, got_tag); end
    if (chk_lat) begin
      vectors++; if (done_cyc !== LAT_RT) begin miscompares++; $display("FAIL %s_latency got=%0d exp=%0d", nm, done_cyc, LAT_RT); end
    end
  endtask

  task automatic test_roundtrip(input logic [127:0] k, input logic [127:0] n, input logic [127:0] t);
    n_ad = 3; n_ct = 2;
    check_roundtrip("roundtrip", k, n, t, 1'b1);
  endtask

  task automatic test_gaps_busy_starts(input logic [127:0] k, input logic [127:0] n, input logic [127:0] t);
    n_ad = 3; n_ct = 2; use_gaps = 1'b1; pulse_busy = 1'b1;
    check_roundtrip("gaps", k, n, t, 1'b0);
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL gaps_idle_after got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int g;
    @(negedge clk);
    key = KAT_KEY; nonce = ~KAT_KEY; tag_in = '0; ad_none = 1'b1; ct_none = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    ct_valid = 1'b1; ct_data = 64'hDEADBEEF_01234567; ct_last = 1'b0;
    g = 0;
    while (!ct_ready && g < 200) begin @(negedge clk); g++; end
    vectors++; if (ct_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ct_ready got=%b exp=1", ct_ready); end
    @(posedge clk); #1;
    vectors++; if (pt_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pt_valid got=%b exp=1", pt_valid); end
    @(negedge clk);
    ct_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if ({busy, done, tag_ok, pt_valid, ad_ready, ct_ready} !== 6'd0) begin
      miscompares++; $display("FAIL rstmid_flags got=%b exp=000000", {busy, done, tag_ok, pt_valid, ad_ready, ct_ready});
    end
    vectors++; if (pt_data !== 64'd0) begin miscompares++; $display("FAIL rstmid_pt_data got=%h exp=0", pt_data); end
    @(negedge clk);
    rst_n = 1'b1;
    n_ad = 0; n_ct = 0;
    run_op(KAT_KEY, KAT_KEY, KAT_TAG);
    vectors++; if (done_cyc !== LAT_KAT) begin miscompares++; $display("FAIL rstmid_kat_latency got=%0d exp=%0d", done_cyc, LAT_KAT); end
    vectors++; if (got_tag !== 1'b1) begin miscompares++; $display("FAIL rstmid_kat_tag_ok got=%b exp=1", got_tag); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired, simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [127:0] rk, rn, rt;
    rk = 128'h8A3F_5C21_0B9E_D476_1F20_3C4B_5A69_7887;
    rn = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    ad_blk[0] = 64'h4153_434F_4E2D_4144; ad_blk[1] = 64'h1122_3344_5566_7788;
    ad_blk[2] = 64'hFFFF_0000_FFFF_0000;
    pt_blk[0] = 64'h0123_4567_89AB_CDEF; pt_blk[1] = 64'hFEDC_BA98_7654_3210;
    n_ad = 3; n_ct = 2;
    m_encrypt(rk, rn, rt);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_kat1();
    test_bad_tag();
    test_roundtrip(rk, rn, rt);
    test_gaps_busy_starts(rk, rn, rt);
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
